// File: rtl/pipeline_skid_stage_pkg.sv
// Shared types for the pipeline skid stage: state encoding and occupancy width.
// Optional feature macro used by this slice: PIPE_STAGE_PERF_EN.
package pipe_stage_pkg;

  localparam int unsigned PS_OCC_W = 2;

  typedef enum logic [1:0] {PS_EMPTY, PS_ONE, PS_FULL} pstate_t;

  // Number of beats held for a given state
  function automatic logic [PS_OCC_W-1:0] occ_of(input pstate_t s);
    logic [PS_OCC_W-1:0] occ;
    occ = PS_OCC_W'(0);
    case (s)
      PS_ONE:  occ = PS_OCC_W'(1);
      PS_FULL: occ = PS_OCC_W'(2);
      default: occ = PS_OCC_W'(0);
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/pipeline_skid_stage_if.sv
// Valid/ready/data handshake bundle; master drives valid+data, slave drives ready.
interface pipeline_skid_stage_if #(
  parameter int unsigned DATA_W = 128
);

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/pipeline_skid_stage_sat_counter.sv
// Saturating event counter with synchronous clear; clear wins over increment.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: clear, saturating increment, or hold
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = CNT_W'(0);
    end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Counter register
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) cnt_q <= CNT_W'(0);
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_skid_stage.sv
// Pipeline stage register with 2-entry skid buffer, flush and registered up_ready.
// Optional perf counters (stall/bubble) are built when PIPE_STAGE_PERF_EN is defined;
// otherwise the counter outputs are tied to zero and perf_clr_i is ignored.
module pipeline_skid_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned       DATA_W    = 128,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int unsigned       CNT_W     = 32
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 flush_i,
  pipeline_skid_stage_if.slave  up,
  pipeline_skid_stage_if.master dn,
  output logic [PS_OCC_W-1:0]  occupancy_o,
  input  logic                 perf_clr_i,
  output logic [CNT_W-1:0]     stall_cnt_o,
  output logic [CNT_W-1:0]     bubble_cnt_o
);

  pstate_t           state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_xfer;
  logic              dn_xfer;

  // Handshake outputs decode the state register only; dn.ready never reaches up.ready
  assign dn.valid    = (state_q != PS_EMPTY);
  assign up.ready    = (state_q != PS_FULL);
  assign dn.data     = main_q;
  assign occupancy_o = occ_of(state_q);

  assign up_xfer = up.valid & up.ready;
  assign dn_xfer = dn.valid & dn.ready;

  // Next state and payload movement; flush overrides everything
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = PS_EMPTY;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      case (state_q)
        PS_EMPTY: begin
          if (up_xfer) begin
            state_d = PS_ONE;
            main_d  = up.data;
          end
        end
        PS_ONE: begin
          if (up_xfer && dn_xfer) begin
            main_d = up.data;
          end else if (up_xfer) begin
            state_d = PS_FULL;
            skid_d  = up.data;
          end else if (dn_xfer) begin
            state_d = PS_EMPTY;
            main_d  = RESET_VAL;
          end
        end
        PS_FULL: begin
          if (dn_xfer) begin
            state_d = PS_ONE;
            main_d  = skid_q;
            skid_d  = RESET_VAL;
          end
        end
        default: begin
          state_d = PS_EMPTY;
          main_d  = RESET_VAL;
          skid_d  = RESET_VAL;
        end
      endcase
    end
  end

  // State and payload registers
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= PS_EMPTY;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr_i (perf_clr_i),
    .inc_i (dn.valid & ~dn.ready),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .CLK   (CLK),
    .nRST  (nRST),
    .clr_i (perf_clr_i),
    .inc_i (~dn.valid),
    .cnt_o (bubble_cnt_o)
  );
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr_i;
  assign stall_cnt_o     = CNT_W'(0);
  assign bubble_cnt_o    = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_skid_stage.sv
// Bench for pipeline_skid_stage: scenario tasks plus a scoreboard monitor.
module tb_pipeline_skid_stage;

  localparam int unsigned DW    = 16;
  localparam int unsigned CW    = 3;
  localparam logic [DW-1:0] RST_V = 16'hA5A5;
`ifdef PIPE_STAGE_PERF_EN
  localparam int PERF_ON = 1;
`else
  localparam int PERF_ON = 0;
`endif

  logic          CLK = 1'b0;
  logic          nRST;
  logic          flush;
  logic          perf_clr;
  logic [1:0]    occupancy;
  logic [CW-1:0] stall_cnt;
  logic [CW-1:0] bubble_cnt;

  int checks = 0;
  int errors = 0;
  logic [DW-1:0] sb[$];

  pipeline_skid_stage_if #(.DATA_W(DW)) up_if ();
  pipeline_skid_stage_if #(.DATA_W(DW)) dn_if ();

  pipeline_skid_stage #(.DATA_W(DW), .RESET_VAL(RST_V), .CNT_W(CW)) dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .flush_i      (flush),
    .up           (up_if.slave),
    .dn           (dn_if.master),
    .occupancy_o  (occupancy),
    .perf_clr_i   (perf_clr),
    .stall_cnt_o  (stall_cnt),
    .bubble_cnt_o (bubble_cnt)
  );

  always #5 CLK = ~CLK;

  // Scoreboard: check held beats against the model, then apply the coming edge's transfers
  always @(negedge CLK) begin
    if (!nRST) begin
      sb.delete();
    end else begin
      checks++;
      if (occupancy !== 2'(sb.size())) begin
        errors++;
        $display("FAIL sb_occupancy: got %0d expected %0d at %0t", occupancy, sb.size(), $time);
      end
      checks++;
      if (up_if.ready !== (sb.size() != 2)) begin
        errors++;
        $display("FAIL sb_up_ready: got %b expected %b at %0t", up_if.ready, (sb.size() != 2), $time);
      end
      checks++;
      if (sb.size() != 0) begin
        if (dn_if.valid !== 1'b1 || dn_if.data !== sb[0]) begin
          errors++;
          $display("FAIL sb_head: got valid=%b data=%h expected valid=1 data=%h at %0t",
                   dn_if.valid, dn_if.data, sb[0], $time);
        end
      end else begin
        if (dn_if.valid !== 1'b0 || dn_if.data !== RST_V) begin
          errors++;
          $display("FAIL sb_empty: got valid=%b data=%h expected valid=0 data=%h at %0t",
                   dn_if.valid, dn_if.data, RST_V, $time);
        end
      end
      if (dn_if.valid && dn_if.ready && sb.size() != 0) void'(sb.pop_front());
      if (up_if.valid && up_if.ready && !flush) sb.push_back(up_if.data);
      if (flush) sb.delete();
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drain();
    int n;
    up_if.valid = 1'b0;
    dn_if.ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 10) begin
      step();
      n++;
    end
    step();
    checks++;
    if (sb.size() != 0 || dn_if.valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: got sb=%0d valid=%b expected sb=0 valid=0", sb.size(), dn_if.valid);
    end
  endtask

  task automatic test_reset();
    nRST = 1'b0; flush = 1'b0; perf_clr = 1'b0;
    up_if.valid = 1'b0; up_if.data = '0; dn_if.ready = 1'b0;
    repeat (2) step();
    chk("rst_dn_valid", DW'(dn_if.valid), DW'(0));
    chk("rst_up_ready", DW'(up_if.ready), DW'(1));
    chk("rst_occ", DW'(occupancy), DW'(0));
    chk("rst_dn_data", dn_if.data, RST_V);
    chk("rst_stall", DW'(stall_cnt), DW'(0));
    chk("rst_bubble", DW'(bubble_cnt), DW'(0));
    nRST = 1'b1;
    step();
  endtask

  task automatic test_stream();
    dn_if.ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      up_if.valid = 1'b1;
      up_if.data  = DW'(i);
      step();
      chk("stream_data", dn_if.data, DW'(i));
      chk("stream_occ", DW'(occupancy), DW'(1));
    end
    drain();
  endtask

  task automatic test_skid_fill();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 16'h00A1;
    step();
    chk("skid_occ1", DW'(occupancy), DW'(1));
    up_if.data = 16'h00B2;
    step();
    chk("skid_occ2", DW'(occupancy), DW'(2));
    chk("skid_ready0", DW'(up_if.ready), DW'(0));
    up_if.data = 16'h00C3;
    step();
    chk("skid_hold_a", dn_if.data, 16'h00A1);
    chk("skid_hold_occ", DW'(occupancy), DW'(2));
    dn_if.ready = 1'b1;
    step();
    chk("skid_out_b", dn_if.data, 16'h00B2);
    step();
    chk("skid_out_c", dn_if.data, 16'h00C3);
    up_if.valid = 1'b0;
    step();
    chk("skid_empty", DW'(dn_if.valid), DW'(0));
    drain();
  endtask

  task automatic test_one_passthrough();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 16'h1111;
    step();
    up_if.data = 16'h2222; dn_if.ready = 1'b1;
    step();
    chk("pass_occ", DW'(occupancy), DW'(1));
    chk("pass_data", dn_if.data, 16'h2222);
    drain();
  endtask

  task automatic test_flush();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 16'h0A0A;
    step();
    up_if.data = 16'h0B0B;
    step();
    up_if.data = 16'h0D0D; flush = 1'b1;
    step();
    flush = 1'b0; up_if.valid = 1'b0;
    chk("flush_valid", DW'(dn_if.valid), DW'(0));
    chk("flush_occ", DW'(occupancy), DW'(0));
    chk("flush_data", dn_if.data, RST_V);
    repeat (3) step();
    chk("flush_no_d", DW'(dn_if.valid), DW'(0));
    // Flush from ONE: downstream beat completes, simultaneous upstream beat is dropped
    up_if.valid = 1'b1; up_if.data = 16'h0E0E;
    step();
    up_if.data = 16'h0F0F; dn_if.ready = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; up_if.valid = 1'b0;
    chk("flush1_occ", DW'(occupancy), DW'(0));
    step();
    chk("flush1_no_f", DW'(dn_if.valid), DW'(0));
    drain();
  endtask

  task automatic test_perf();
    up_if.valid = 1'b0; dn_if.ready = 1'b0;
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr0_stall", DW'(stall_cnt), DW'(0));
    chk("perf_clr0_bubble", DW'(bubble_cnt), DW'(0));
    repeat (2) step();
    up_if.valid = 1'b1; up_if.data = 16'h0055;
    step();
    up_if.valid = 1'b0;
    repeat (5) step();
    chk("perf_stall5", DW'(stall_cnt), DW'(PERF_ON * 5));
    chk("perf_bubble3", DW'(bubble_cnt), DW'(PERF_ON * 3));
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("perf_flush_keep", DW'(stall_cnt), DW'(PERF_ON * 6));
    up_if.valid = 1'b1; up_if.data = 16'h0066;
    step();
    up_if.valid = 1'b0;
    repeat (4) step();
    chk("perf_sat", DW'(stall_cnt), DW'(PERF_ON * 7));
    chk("perf_bubble4", DW'(bubble_cnt), DW'(PERF_ON * 4));
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_clr_stall", DW'(stall_cnt), DW'(0));
    chk("perf_clr_bubble", DW'(bubble_cnt), DW'(0));
    drain();
  endtask

  task automatic test_reset_midop();
    dn_if.ready = 1'b0;
    up_if.valid = 1'b1; up_if.data = 16'h00AA;
    step();
    up_if.data = 16'h00BB;
    step();
    chk("mid_full", DW'(occupancy), DW'(2));
    up_if.valid = 1'b0;
    nRST = 1'b0;
    #1;
    chk("mid_valid", DW'(dn_if.valid), DW'(0));
    chk("mid_ready", DW'(up_if.ready), DW'(1));
    chk("mid_occ", DW'(occupancy), DW'(0));
    chk("mid_data", dn_if.data, RST_V);
    chk("mid_stall", DW'(stall_cnt), DW'(0));
    chk("mid_bubble", DW'(bubble_cnt), DW'(0));
    step();
    nRST = 1'b1;
    dn_if.ready = 1'b1;
    repeat (2) step();
    chk("mid_after", DW'(dn_if.valid), DW'(0));
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_fill();
    test_one_passthrough();
    test_flush();
    test_perf();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
